// File: rtl/fetch_controller_pkg.sv
// Shared fetch-path definitions: FSM state encoding and PC arithmetic constants.
package fetch_controller_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_DRAIN = 2'd1,
    S_OUT   = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INC        = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues word fetches, holds one instruction for decode,
// and handles branch redirects including the in-flight request drain.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_drain_addr;
  logic [31:0]  r_inst;
  logic [31:0]  r_inst_pc;
  logic [31:0]  w_branch_pc;

  assign w_branch_pc = branch_pc & PC_ALIGN_MASK;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_drain_addr <= RESET_PC;
      r_inst       <= '0;
      r_inst_pc    <= '0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (branch_taken) begin
            r_pc <= w_branch_pc;
            // Without an ack the old request is still outstanding and must be drained.
            if (!imem_ack) begin
              r_drain_addr <= r_pc;
              r_state      <= S_DRAIN;
            end
          end else if (imem_ack) begin
            r_inst    <= imem_rdata;
            r_inst_pc <= r_pc;
            r_pc      <= r_pc + PC_INC;
            r_state   <= S_OUT;
          end
        end
        S_DRAIN: begin
          if (branch_taken) r_pc <= w_branch_pc;
          if (imem_ack) r_state <= S_REQ;
        end
        S_OUT: begin
          if (branch_taken) begin
            r_pc    <= w_branch_pc;
            r_state <= S_REQ;
          end else if (inst_ready) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  always_comb begin
    imem_req   = !reset && ((r_state == S_REQ) || (r_state == S_DRAIN));
    imem_addr  = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
    inst_valid = (r_state == S_OUT);
    inst       = r_inst;
    inst_pc    = r_inst_pc;
  end

endmodule
